// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between the core and the loader, one access at a time
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie breaking; default is fixed core-over-loader priority.
module mem_port_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int MEM_LAT = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          core_req,
   input  logic          core_we,
   input  logic [AW-1:0] core_addr,
   input  logic [DW-1:0] core_wdata,
   output logic [DW-1:0] core_rdata,
   output logic          core_ack,
   input  logic          ldr_req,
   input  logic          ldr_we,
   input  logic [AW-1:0] ldr_addr,
   input  logic [DW-1:0] ldr_wdata,
   output logic [DW-1:0] ldr_rdata,
   output logic          ldr_ack,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy,
   output logic          owner
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } state_t;

   localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

   state_t        state;
   state_t        state_nxt;
   logic          lat_we;
   logic [AW-1:0] lat_addr;
   logic [DW-1:0] lat_wdata;
   logic          owner_r;
   logic [3:0]    wait_cnt;
   logic [DW-1:0] core_rdata_r;
   logic [DW-1:0] ldr_rdata_r;
   logic          any_req;
   logic          grant_ldr;

   assign any_req = core_req | ldr_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   // last_owner: 0 = core, 1 = loader; on a tie the other requester wins
   logic last_owner;

   assign grant_ldr = ldr_req & (~core_req | ~last_owner);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_owner <= 1'b1;
      end else if (state == IDLE && any_req) begin
         last_owner <= grant_ldr;
      end
   end
`else
   assign grant_ldr = ldr_req & ~core_req;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (any_req) begin
               state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            state_nxt = lat_we ? RESP : WAIT;
         end
         WAIT: begin
            if (wait_cnt == 4'd0) begin
               state_nxt = RESP;
            end
         end
         RESP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Command latch, wait counter and per-requester read data
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lat_we       <= 1'b0;
         lat_addr     <= '0;
         lat_wdata    <= '0;
         owner_r      <= 1'b0;
         wait_cnt     <= 4'd0;
         core_rdata_r <= '0;
         ldr_rdata_r  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  owner_r   <= grant_ldr;
                  lat_we    <= grant_ldr ? ldr_we    : core_we;
                  lat_addr  <= grant_ldr ? ldr_addr  : core_addr;
                  lat_wdata <= grant_ldr ? ldr_wdata : core_wdata;
               end
            end
            ACCESS: begin
               if (!lat_we) begin
                  wait_cnt <= LAT_INIT;
               end
            end
            WAIT: begin
               if (wait_cnt != 4'd0) begin
                  wait_cnt <= wait_cnt - 4'd1;
               end else if (owner_r) begin
                  ldr_rdata_r <= mem_rdata;
               end else begin
                  core_rdata_r <= mem_rdata;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign mem_en     = (state == ACCESS);
   assign mem_we     = (state == ACCESS) & lat_we;
   assign mem_addr   = lat_addr;
   assign mem_wdata  = lat_wdata;
   assign busy       = (state != IDLE);
   assign owner      = owner_r;
   assign core_ack   = (state == RESP) & ~owner_r;
   assign ldr_ack    = (state == RESP) & owner_r;
   assign core_rdata = core_rdata_r;
   assign ldr_rdata  = ldr_rdata_r;

endmodule
